// File: rtl/if_fetch.sv
// Single-issue instruction fetch front end: one outstanding SRAM request, branch redirect, stall hold.
// Optional macro FETCH_ALIGN_CHK_EN traps misaligned redirects instead of forcing word alignment.
module if_fetch #(
  parameter int unsigned     PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall_i,
  input  logic            branch_en_i,
  input  logic [PC_W-1:0] branch_addr_i,
  output logic            imem_req_o,
  output logic [PC_W-1:0] imem_addr_o,
  input  logic            imem_ack_i,
  input  logic [PC_W-1:0] imem_rdata_i,
  output logic [PC_W-1:0] inst_o,
  output logic [PC_W-1:0] inst_pc_o,
  output logic            inst_valid_o,
  output logic [PC_W-1:0] pc_outside,
  output logic            exc_misalign_o
);

  typedef enum logic [1:0] {StBoot, StFetch, StKill, StHold} state_e;

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] kill_addr_q, kill_addr_d;
  logic [PC_W-1:0] inst_q, inst_d;
  logic [PC_W-1:0] inst_pc_q, inst_pc_d;
  logic            valid_q, valid_d;
  logic            exc_q, exc_d;
  logic [PC_W-1:0] br_target;
  logic            br_misalign;

`ifdef FETCH_ALIGN_CHK_EN
  assign br_target      = branch_addr_i;
  assign br_misalign    = branch_en_i && (branch_addr_i[1:0] != 2'b00);
  assign exc_misalign_o = exc_q;
`else
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^branch_addr_i[1:0];
  assign br_target       = {branch_addr_i[PC_W-1:2], 2'b00};
  assign br_misalign     = 1'b0;
  assign exc_misalign_o  = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    kill_addr_d = kill_addr_q;
    inst_d      = inst_q;
    inst_pc_d   = inst_pc_q;
    valid_d     = valid_q & stall_i;  // present each instruction once unless held
    exc_d       = exc_q;
    if (br_misalign && !exc_q) begin
      exc_d   = 1'b1;
      valid_d = 1'b0;
      state_d = StHold;
    end else begin
      unique case (state_q)
        StBoot: begin
          valid_d = 1'b0;
          state_d = StFetch;
          if (branch_en_i) pc_d = br_target;
        end
        StFetch: begin
          if (branch_en_i) begin
            pc_d = br_target;
            // Request in flight keeps its old address; its data gets dropped in StKill.
            if (!imem_ack_i) begin
              kill_addr_d = pc_q;
              state_d     = StKill;
            end
          end else if (imem_ack_i) begin
            inst_d    = imem_rdata_i;
            inst_pc_d = pc_q;
            valid_d   = 1'b1;
            pc_d      = pc_q + PC_W'(4);
            if (stall_i) state_d = StHold;
          end
        end
        StKill: begin
          if (branch_en_i) pc_d = br_target;
          if (imem_ack_i) begin
            valid_d = 1'b0;
            state_d = StFetch;
          end
        end
        StHold: begin
          valid_d = valid_q;
          // A trapped misaligned redirect parks here until reset.
          if (!exc_q) begin
            if (branch_en_i) begin
              pc_d    = br_target;
              valid_d = 1'b0;
            end
            if (!stall_i) state_d = StFetch;
          end
        end
        default: state_d = StBoot;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StBoot;
      pc_q        <= RESET_PC;
      kill_addr_q <= '0;
      inst_q      <= '0;
      inst_pc_q   <= '0;
      valid_q     <= 1'b0;
      exc_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      kill_addr_q <= kill_addr_d;
      inst_q      <= inst_d;
      inst_pc_q   <= inst_pc_d;
      valid_q     <= valid_d;
      exc_q       <= exc_d;
    end
  end

  assign imem_req_o   = (state_q == StFetch) || (state_q == StKill);
  assign imem_addr_o  = (state_q == StKill) ? kill_addr_q : pc_q;
  assign inst_o       = inst_q;
  assign inst_pc_o    = inst_pc_q;
  assign inst_valid_o = valid_q;
  assign pc_outside   = pc_q;

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: directed scenarios plus a random phase, checked every cycle against a
// transaction-level reference model and a variable-latency SRAM model.
module tb_if_fetch;

  localparam logic [31:0] Key = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst, stall, br_en, ack;
  logic [31:0] br_addr, rdata;
  logic        req, valid, exc;
  logic [31:0] addr, inst, ipc, pc_out;

  if_fetch #(.PC_W(32), .RESET_PC(32'h0)) dut (
    .clk            (clk),
    .rst            (rst),
    .stall_i        (stall),
    .branch_en_i    (br_en),
    .branch_addr_i  (br_addr),
    .imem_req_o     (req),
    .imem_addr_o    (addr),
    .imem_ack_i     (ack),
    .imem_rdata_i   (rdata),
    .inst_o         (inst),
    .inst_pc_o      (ipc),
    .inst_valid_o   (valid),
    .pc_outside     (pc_out),
    .exc_misalign_o (exc)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // SRAM model; lat == 0 picks a random latency of 1..3 per request
  bit          mem_en, mem_busy;
  int          mem_cnt, lat;
  logic [31:0] mem_addr;

  // Reference model: fetch pointer, whether the next returning word is stale, presented instruction
  bit          m_boot, m_hold, m_drop, m_valid, m_exc;
  logic [31:0] m_pc, m_old, m_inst, m_ipc;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_update();
    logic [31:0] tgt;
    bit          mis;
    tgt = {br_addr[31:2], 2'b00};
`ifdef FETCH_ALIGN_CHK_EN
    mis = br_en && (br_addr[1:0] != 2'b00);
`else
    mis = 1'b0;
`endif
    if (rst) begin
      m_boot = 1; m_hold = 0; m_drop = 0; m_valid = 0; m_exc = 0;
      m_pc = 32'h0; m_old = 32'h0; m_inst = 32'h0; m_ipc = 32'h0;
      return;
    end
    if (m_exc) return;
    if (mis) begin
      m_exc = 1; m_hold = 1; m_boot = 0; m_drop = 0; m_valid = 0;
      return;
    end
    if (m_boot) begin
      m_boot = 0; m_valid = 0;
      if (br_en) m_pc = tgt;
    end else if (m_hold) begin
      if (br_en) begin m_pc = tgt; m_valid = 0; end
      if (!stall) m_hold = 0;
    end else if (m_drop) begin
      if (br_en) m_pc = tgt;
      if (ack) begin m_drop = 0; m_valid = 0; end
      else m_valid = m_valid && stall;
    end else if (ack && !br_en) begin
      m_inst = rdata; m_ipc = m_pc; m_valid = 1; m_pc = m_pc + 32'd4; m_hold = stall;
    end else begin
      m_valid = m_valid && stall;
      if (br_en) begin
        if (!ack) begin m_drop = 1; m_old = m_pc; end
        m_pc = tgt;
      end
    end
  endtask

  task automatic mem_update(input logic rst_s);
    if (!mem_en) return;
    if (rst_s) begin mem_busy = 0; ack = 0; return; end
    if (ack) begin
      ack = 0; mem_busy = 0;
    end else if (mem_busy) begin
      mem_cnt--;
      if (mem_cnt == 0) begin ack = 1; rdata = mem_addr ^ Key; end
    end
    if (!mem_busy && req) begin
      mem_busy = 1; mem_addr = addr;
      mem_cnt  = (lat == 0) ? int'($urandom_range(1, 3)) : lat;
    end
  endtask

  task automatic check_all();
    chk("pc_outside", pc_out, m_pc);
    chk("req", {31'b0, req}, {31'b0, !m_boot && !m_hold});
    if (!m_boot && !m_hold) chk("addr", addr, m_drop ? m_old : m_pc);
    chk("valid", {31'b0, valid}, {31'b0, m_valid});
    chk("inst", inst, m_inst);
    chk("inst_pc", ipc, m_ipc);
    chk("exc", {31'b0, exc}, {31'b0, m_exc});
  endtask

  task automatic step();
    logic rst_s;
    rst_s = rst;
    model_update();
    @(posedge clk);
    #1;
    br_en = 0;
    mem_update(rst_s);
    check_all();
  endtask

  initial begin
    bit found;
    rst = 1; stall = 0; br_en = 0; br_addr = 0; ack = 0; rdata = 0;
    mem_en = 1; mem_busy = 0; mem_cnt = 0; mem_addr = 0; lat = 1;
    #1;
    step(); step();
    chk("rst_pc", pc_out, 32'h0);
    chk("rst_req", {31'b0, req}, 32'h0);
    chk("rst_inst", inst, 32'h0);

    // Boot: one idle cycle, then the first request at RESET_PC
    rst = 0;
    step();
    chk("first_req", {31'b0, req}, 32'h1);
    chk("first_addr", addr, 32'h0);

    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (valid && ipc == 32'h0) chk("inst0", inst, 32'hA5A5_0000);
      if (valid && ipc == 32'h4) chk("inst4", inst, 32'hA5A5_0004);
      if (ack && mem_addr == 32'h8) found = 1;
      else step();
    end
    chk("wait_ack8", {31'b0, found}, 32'h1);

    // Stall from the ack of pc 8 for five cycles
    stall = 1;
    repeat (5) begin
      step();
      chk("hold_ipc", ipc, 32'h8);
      chk("hold_req", {31'b0, req}, 32'h0);
    end
    stall = 0;
    lat = 3;
    step();
    chk("resume_req", {31'b0, req}, 32'h1);
    chk("resume_addr", addr, 32'hC);

    // Redirect while the request for 0x10 is pending
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (mem_busy && mem_addr == 32'h10 && mem_cnt == 3) found = 1;
      else step();
    end
    chk("wait_req10", {31'b0, found}, 32'h1);
    br_en = 1; br_addr = 32'h100;
    step();
    chk("kill_addr", addr, 32'h10);
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (valid) found = 1;
      else step();
    end
    chk("wait_valid_after_kill", {31'b0, found}, 32'h1);
    chk("after_kill_ipc", ipc, 32'h100);

    // Redirect coincident with the ack for 0x20
    lat = 1;
    br_en = 1; br_addr = 32'h18;
    step();
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (ack && mem_addr == 32'h20) found = 1;
      else step();
    end
    chk("wait_ack20", {31'b0, found}, 32'h1);
    br_en = 1; br_addr = 32'h200;
    step();
    chk("br_ack_valid", {31'b0, valid}, 32'h0);
    chk("br_ack_req", {31'b0, req}, 32'h1);
    chk("br_ack_addr", addr, 32'h200);

    // PC wrap
    br_en = 1; br_addr = 32'hFFFF_FFF8;
    step();
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (valid && ipc == 32'hFFFF_FFFC) found = 1;
      else step();
    end
    chk("wait_wrap", {31'b0, found}, 32'h1);
    chk("wrap_pc", pc_out, 32'h0);

    // Random traffic
    lat = 0;
    repeat (400) begin
      stall = ($urandom_range(0, 99) < 25);
      br_en = ($urandom_range(0, 99) < 6);
      br_addr = $urandom;
`ifdef FETCH_ALIGN_CHK_EN
      br_addr[1:0] = 2'b00;
`endif
      step();
    end
    stall = 0;

    // Acks during reset and boot are ignored
    mem_en = 0; ack = 1; rdata = 32'hDEAD_BEEF;
    rst = 1;
    step();
    rst = 0;
    step();
    chk("boot_ack_valid", {31'b0, valid}, 32'h0);
    chk("boot_ack_pc", pc_out, 32'h0);
    ack = 0; mem_busy = 0; mem_en = 1; lat = 1;

    // Misaligned redirect
    br_en = 1; br_addr = 32'h102;
    step();
`ifdef FETCH_ALIGN_CHK_EN
    chk("mis_exc", {31'b0, exc}, 32'h1);
    chk("mis_pc", pc_out, 32'h0);
    repeat (4) begin
      stall = ($urandom_range(0, 1) == 1);
      step();
      chk("mis_req", {31'b0, req}, 32'h0);
      chk("mis_exc_sticky", {31'b0, exc}, 32'h1);
    end
    stall = 0;
`else
    chk("lsb_pc", pc_out, 32'h100);
    chk("lsb_exc", {31'b0, exc}, 32'h0);
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (req && addr == 32'h100) found = 1;
      else step();
    end
    chk("lsb_req_addr", {31'b0, found}, 32'h1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/if_fetch.md
IF_FETCH -- requirements
Module: if_fetch

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 The block SHALL have parameter PC_W, default 32: PC and instruction width.
REQ-003 The block SHALL have a single clock and a synchronous, active-high reset.
REQ-004 The block SHALL have these ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous active-high reset
- stall_i  in  1  downstream not ready; hold presented instruction
- branch_en_i  in  1  redirect request, one-cycle pulse
- branch_addr_i  in  PC_W  redirect target
- imem_req_o  out  1  instruction SRAM request
- imem_addr_o  out  PC_W  SRAM word address (byte PC)
- imem_ack_i  in  1  SRAM data valid, at least 1 cycle after req
- imem_rdata_i  in  PC_W  SRAM read data
- inst_o  out  PC_W  fetched instruction
- inst_pc_o  out  PC_W  PC of inst_o
- inst_valid_o  out  1  inst_o/inst_pc_o valid
- pc_outside  out  PC_W  current fetch PC, for testbench observation
- exc_misalign_o  out  1  misaligned redirect flag

Function
REQ-005 The FSM SHALL have states BOOT, FETCH, KILL, HOLD.
REQ-006 BOOT SHALL last exactly one cycle after reset release, with imem_req_o=0, then go to FETCH.
REQ-007 In FETCH, imem_req_o=1 and imem_addr_o=pc; both SHALL stay stable until imem_ack_i.
REQ-008 On imem_ack_i in FETCH with no branch: inst_o<=imem_rdata_i, inst_pc_o<=pc, inst_valid_o<=1, pc<=pc+4 (mod 2^PC_W, wrap from FFFF_FFFC to 0), stay in FETCH (back-to-back fetch, 1 inst per ack).
REQ-009 If stall_i=1 when imem_ack_i arrives, capture still occurs; next state SHALL be HOLD with no new request.
REQ-010 In HOLD, inst_o/inst_pc_o/inst_valid_o SHALL stay constant; when stall_i falls, go to FETCH next cycle.
REQ-011 While inst_valid_o=1, stall_i=0 and no new ack arrives, inst_valid_o SHALL drop to 0 after one cycle (each instruction presented once).
REQ-012 branch_en_i in FETCH without ack SHALL load pc<=branch_addr_i and go to KILL; the outstanding request stays asserted at its old address.
REQ-013 In KILL, the next imem_ack_i data SHALL be discarded (inst_valid_o=0), then FETCH resumes at the branch target.
REQ-014 branch_en_i coincident with imem_ack_i SHALL discard the data, load pc<=branch_addr_i, and go to FETCH (no KILL).
REQ-015 branch_en_i in HOLD or BOOT SHALL load pc<=branch_addr_i and clear inst_valid_o; the state transition is unchanged.
REQ-016 Branch SHALL take priority over stall; branch in KILL SHALL overwrite pc and stay in KILL.
REQ-017 pc_outside SHALL equal pc at all times.

Reset
REQ-018 With rst=1 at a rising edge: state<=BOOT, pc<=RESET_PC, imem_req_o=0, inst_o=0, inst_pc_o=0, inst_valid_o=0, exc_misalign_o=0.
REQ-019 Reset mid-request SHALL abandon the request; an ack arriving during or after reset, before the first FETCH, SHALL be ignored.

Configuration
REQ-020 With macro FETCH_ALIGN_CHK_EN defined: a branch with branch_addr_i[1:0]!=0 SHALL set exc_misalign_o (sticky until reset), leave pc unchanged and halt in HOLD with imem_req_o=0, ignoring stall_i.
REQ-021 Without FETCH_ALIGN_CHK_EN: branch_addr_i[1:0] SHALL be forced to 0 on load, and exc_misalign_o SHALL be tied 0.

Verification
REQ-022 Reset, 1-cycle-latency ack memory returning addr^32'hA5A5_0000 -> first req at cycle 2 after release, pc_outside 0,4,8,..., inst_o 0xA5A5_0000, 0xA5A5_0004, ...
REQ-023 stall_i=1 for 5 cycles from the ack of pc 8 -> inst_o/inst_pc_o=8 held, no req; fetch of 0xC resumes 1 cycle after stall falls.
REQ-024 branch to 0x100 while req for 0x10 pending, 3-cycle ack -> 0x10 data dropped, next inst_pc_o=0x100.
REQ-025 branch to 0x200 same cycle as ack for 0x20 -> no valid for 0x20, next req addr 0x200.
REQ-026 pc=0xFFFF_FFFC fetched -> pc_outside wraps to 0x0000_0000.
REQ-027 branch to 0x102: with FETCH_ALIGN_CHK_EN exc_misalign_o=1 and req stays 0; without the macro, the next req addr is 0x100.
